// File: rtl/periph_reset_seq.sv
// -----------------------------------------------------------------------------
// periph_reset_seq
//
// Staged peripheral-reset sequencer on the 8-bit CSR bus. A start pulse (or a
// CTRL.go write) releases the reset lines one at a time, stage 0 first. The gap
// between consecutive stage events is a programmable number of ce ticks. A
// shutdown pulse (or CTRL.off) re-asserts the released lines in reverse order.
// The HOLD register keeps individual stages in reset. A held stage still uses
// its time slot in the sequence.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   ce        single-cycle pacing tick (32 kHz)
//   start     single-cycle pulse, begin release sequence
//   shutdown  single-cycle pulse, begin reverse assertion
//   csr_a     CSR address
//   csr_di    CSR write data
//   csr_we    CSR write strobe
//   csr_do    CSR read data, 8'h00 outside BASE_ADDR..BASE_ADDR+2 (OR-bus)
//   rst_out   per-stage reset, 1 = held in reset
//   busy      release or shutdown sequence in progress
//   done      all stages released, sequencer idle
//
// CSR map:
//   +0 CTRL   W: bit0 go, bit1 off   R: {idx[3:0], 2'b0, done, busy}
//   +1 HOLD   R/W, NUM_STAGES bits
//   +2 DELAY  R/W gap in ce ticks (only with PERIPH_RESET_SEQ_CSR_DELAY_EN)
//
// Optional feature macro: PERIPH_RESET_SEQ_CSR_DELAY_EN
//   When defined, the gap comes from the DELAY register. A write to DELAY
//   takes effect at the next counter reload.
//   When undefined, the gap is fixed at STAGE_DELAY. In that build +2 reads
//   8'h00 and writes to it are ignored.
// -----------------------------------------------------------------------------
module periph_reset_seq #(
    parameter logic [4:0] BASE_ADDR   = 5'h1d,
    parameter int         NUM_STAGES  = 4,
    parameter logic [7:0] STAGE_DELAY = 8'd4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  start,
    input  logic                  shutdown,
    input  logic [4:0]            csr_a,
    input  logic [7:0]            csr_di,
    input  logic                  csr_we,
    output logic [7:0]            csr_do,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_ON   = 2'd2;
    localparam logic [1:0] ST_DOWN = 2'd3;

    localparam logic [4:0] ADDR_CTRL  = BASE_ADDR;
    localparam logic [4:0] ADDR_HOLD  = BASE_ADDR + 5'd1;
    localparam logic [4:0] ADDR_DELAY = BASE_ADDR + 5'd2;

    localparam logic [3:0] LAST_IDX = 4'(NUM_STAGES - 1);

    logic [1:0]            state;
    logic [3:0]            idx;
    logic [7:0]            cnt;
    logic [NUM_STAGES-1:0] rel;
    logic [NUM_STAGES-1:0] hold;
    logic [7:0]            reload;

    logic sel_ctrl;
    logic sel_hold;
    logic sel_delay;
    logic go;
    logic off;

    // One-hot select of stage i. The loop avoids indexing rel with a wider idx.
    function automatic logic [NUM_STAGES-1:0] stage_bit(input logic [3:0] i);
        logic [NUM_STAGES-1:0] m;
        m = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            if (i == 4'(s)) begin
                m[s] = 1'b1;
            end
        end
        return m;
    endfunction

    assign sel_ctrl  = (csr_a == ADDR_CTRL);
    assign sel_hold  = (csr_a == ADDR_HOLD);
    assign sel_delay = (csr_a == ADDR_DELAY);

    // A CTRL write behaves exactly like the matching pulse input.
    assign go  = start    | (csr_we & sel_ctrl & csr_di[0]);
    assign off = shutdown | (csr_we & sel_ctrl & csr_di[1]);

    assign busy = (state == ST_UP) || (state == ST_DOWN);
    assign done = (state == ST_ON);

`ifdef PERIPH_RESET_SEQ_CSR_DELAY_EN
    logic [7:0] delay_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_q <= STAGE_DELAY;
        end else if (csr_we && sel_delay) begin
            delay_q <= csr_di;
        end
    end

    assign reload = delay_q;
`else
    assign reload = STAGE_DELAY;
`endif

    // Sequencer. An event happens on the cycle after cnt reaches zero, so the
    // gap is D ce ticks plus one clk. With D = 0 there is one event per clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_OFF;
            idx   <= 4'd0;
            cnt   <= STAGE_DELAY;
            rel   <= '0;
        end else begin
            case (state)
                ST_OFF: begin
                    // shutdown wins over a simultaneous start
                    if (go && !off) begin
                        state <= ST_UP;
                        idx   <= 4'd0;
                        cnt   <= reload;
                    end
                end
                ST_UP: begin
                    if (off) begin
                        state <= ST_DOWN;
                        cnt   <= reload;
                    end else if (cnt == 8'd0) begin
                        rel <= rel | stage_bit(idx);
                        idx <= idx + 4'd1;
                        cnt <= reload;
                        if (idx == LAST_IDX) begin
                            state <= ST_ON;
                        end
                    end else if (ce) begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_ON: begin
                    if (off) begin
                        state <= ST_DOWN;
                        cnt   <= reload;
                    end else if (go) begin
                        state <= ST_UP;
                        rel   <= '0;
                        idx   <= 4'd0;
                        cnt   <= reload;
                    end
                end
                default: begin
                    // ST_DOWN. Shutdown during UP before any release leaves
                    // nothing to re-assert.
                    if (idx == 4'd0) begin
                        state <= ST_OFF;
                    end else if (cnt == 8'd0) begin
                        rel <= rel & ~stage_bit(idx - 4'd1);
                        idx <= idx - 4'd1;
                        cnt <= reload;
                        if (idx == 4'd1) begin
                            state <= ST_OFF;
                        end
                    end else if (ce) begin
                        cnt <= cnt - 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= '0;
        end else if (csr_we && sel_hold) begin
            hold <= csr_di[NUM_STAGES-1:0];
        end
    end

    // Registered output. It lags rel and hold by one clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_out <= '1;
        end else begin
            rst_out <= ~rel | hold;
        end
    end

    always_comb begin
        csr_do = 8'h00;
        if (sel_ctrl) begin
            csr_do = {idx, 2'b00, done, busy};
        end else if (sel_hold) begin
            csr_do = 8'(hold);
        end
`ifdef PERIPH_RESET_SEQ_CSR_DELAY_EN
        else if (sel_delay) begin
            csr_do = delay_q;
        end
`endif
    end

    // Write-data bits beyond the implemented register fields are don't-care.
    logic unused_di;
    assign unused_di = ^{csr_di, sel_delay};

endmodule
